// File: rtl/mc_controller.sv
// Multi-cycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing.
// Define PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_zf,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_iord,
  output logic       ir_wren,
  output logic       pc_wren,
  output logic [2:0] pc_control,
  output logic       reg_file_wren,
  output logic       reg_file_dmux_sel,
  output logic [2:0] state,
  output logic       halted
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   halted_q;
  logic   is_load, is_store;

  // Loads occupy opcodes 0x20-0x26, stores 0x28-0x2E.
  assign is_load  = (op[5:3] == 3'b100) && (op[2:0] != 3'b111);
  assign is_store = (op[5:3] == 3'b101) && (op[2:0] != 3'b111);

  always_comb begin
    state_d           = state_q;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_iord          = 1'b0;
    ir_wren           = 1'b0;
    pc_wren           = 1'b0;
    pc_control        = 3'b000;
    reg_file_wren     = 1'b0;
    reg_file_dmux_sel = 1'b1;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_wren = 1'b1;
          pc_wren = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (op == 6'h02) begin
          pc_wren    = 1'b1;
          pc_control = 3'b001;
          state_d    = FETCH;
        end else if (op == 6'h03) begin
          pc_wren       = 1'b1;
          pc_control    = 3'b001;
          reg_file_wren = 1'b1;
          state_d       = FETCH;
        end else if (op == 6'h00 && funct == 6'h0C) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WB;
        if (op == 6'h04) begin
          pc_wren    = alu_zf;
          pc_control = 3'b011;
          state_d    = FETCH;
        end else if (op == 6'h05) begin
          pc_wren    = !alu_zf;
          pc_control = 3'b011;
          state_d    = FETCH;
        end else if (op == 6'h00 && funct == 6'h08) begin
          pc_wren    = 1'b1;
          pc_control = 3'b010;
          state_d    = FETCH;
        end else if (op == 6'h00 && funct == 6'h09) begin
          pc_wren       = 1'b1;
          pc_control    = 3'b010;
          reg_file_wren = 1'b1;
          state_d       = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_iord = 1'b1;
        mem_we   = is_store;
        if (mem_ready) state_d = is_store ? FETCH : WB;
      end
      WB: begin
        reg_file_wren     = 1'b1;
        reg_file_dmux_sel = !is_load;
        state_d           = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    // While reset is held no request or write may escape, even mid-handshake.
    if (!rst_n) begin
      mem_req           = 1'b0;
      mem_we            = 1'b0;
      mem_iord          = 1'b0;
      ir_wren           = 1'b0;
      pc_wren           = 1'b0;
      pc_control        = 3'b000;
      reg_file_wren     = 1'b0;
      reg_file_dmux_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_q | (state_d == HALT);
    end
  end

  assign state  = state_q;
  assign halted = halted_q;

`ifdef PERF_CNT_EN
  // An instruction retires whenever the FSM re-enters FETCH from another state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      if (state_q != HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (state_d == FETCH && state_q != FETCH) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: each instruction is expanded into its
// expected per-cycle output sequence, driven with random stimulus and compared.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        alu_zf = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_iord, ir_wren, pc_wren;
  logic [2:0]  pc_control;
  logic        reg_file_wren, reg_file_dmux_sel;
  logic [2:0]  state;
  logic        halted;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .alu_zf(alu_zf),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_iord(mem_iord), .ir_wren(ir_wren), .pc_wren(pc_wren),
    .pc_control(pc_control), .reg_file_wren(reg_file_wren),
    .reg_file_dmux_sel(reg_file_dmux_sel), .state(state), .halted(halted)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam int C_J = 0, C_JAL = 1, C_BEQ = 2, C_BNE = 3, C_JR = 4,
                 C_JALR = 5, C_ALU = 6, C_LD = 7, C_ST = 8, C_SYS = 9;

  // One expected clock cycle: inputs to apply and the outputs they must produce.
  typedef struct {
    bit         rst;
    bit         chk;
    logic [2:0] st;
    logic [5:0] op;
    logic [5:0] funct;
    bit         io_rand;
    bit         rdy;
    bit         zf;
    bit         req, we, iord, ir, pc;
    logic [2:0] ctl;
    bit         rf, dmux, hlt;
    bit         ends;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  bit          exp_valid = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_cyc = 32'd0;
  logic [31:0] m_ins = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] st, input logic [5:0] o, input logic [5:0] f);
    rec_t r;
    r.rst = 0; r.chk = 1; r.st = st; r.op = o; r.funct = f; r.io_rand = 0;
    r.rdy = 1'($urandom_range(0, 1)); r.zf = 1'($urandom_range(0, 1));
    r.req = 0; r.we = 0; r.iord = 0; r.ir = 0; r.pc = 0; r.ctl = 3'd0;
    r.rf = 0; r.dmux = 1; r.hlt = 0; r.ends = 0;
    return r;
  endfunction

  // Expand one instruction of a given class into its cycle-by-cycle expectations.
  task automatic build(input int cls, input logic [5:0] o, input logic [5:0] f,
                       input int wf, input int wm, input bit zf_exec);
    rec_t r;
    for (int i = 0; i < wf; i++) begin
      r = mk(3'd0, o, f); r.io_rand = 1; r.rdy = 0; r.req = 1; q.push_back(r);
    end
    r = mk(3'd0, o, f); r.io_rand = 1; r.rdy = 1; r.req = 1; r.ir = 1; r.pc = 1;
    q.push_back(r);
    r = mk(3'd1, o, f);
    if (cls == C_J || cls == C_JAL) begin
      r.pc = 1; r.ctl = 3'd1; r.rf = (cls == C_JAL); r.ends = 1;
      q.push_back(r);
    end else if (cls == C_SYS) begin
      q.push_back(r);
    end else begin
      q.push_back(r);
      r = mk(3'd2, o, f); r.zf = zf_exec;
      if (cls == C_BEQ || cls == C_BNE) begin
        r.pc = (cls == C_BEQ) ? zf_exec : !zf_exec; r.ctl = 3'd3; r.ends = 1;
        q.push_back(r);
      end else if (cls == C_JR || cls == C_JALR) begin
        r.pc = 1; r.ctl = 3'd2; r.rf = (cls == C_JALR); r.ends = 1;
        q.push_back(r);
      end else begin
        q.push_back(r);
        if (cls == C_LD || cls == C_ST) begin
          for (int i = 0; i <= wm; i++) begin
            r = mk(3'd3, o, f); r.rdy = (i == wm); r.req = 1; r.iord = 1;
            r.we = (cls == C_ST); r.ends = (i == wm) && (cls == C_ST);
            q.push_back(r);
          end
        end
        if (cls != C_ST) begin
          r = mk(3'd4, o, f); r.rf = 1; r.dmux = (cls != C_LD); r.ends = 1;
          q.push_back(r);
        end
      end
    end
  endtask

  task automatic add_halt(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = mk(3'd5, 6'd0, 6'd0); r.io_rand = 1; r.hlt = 1; q.push_back(r);
    end
  endtask

  // First reset cycle leaves state unchecked; later ones must already sit in FETCH.
  task automatic add_reset(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = mk(3'd0, 6'($urandom), 6'($urandom)); r.rst = 1; r.chk = (i != 0);
      q.push_back(r);
    end
  endtask

  function automatic bit is_special(input logic [5:0] o);
    return (o == 6'h00) || (o >= 6'h02 && o <= 6'h05) ||
           (o >= 6'h20 && o <= 6'h26) || (o >= 6'h28 && o <= 6'h2E);
  endfunction

  task automatic pick_op(input int cls, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom);
    case (cls)
      C_J:    o = 6'h02;
      C_JAL:  o = 6'h03;
      C_BEQ:  o = 6'h04;
      C_BNE:  o = 6'h05;
      C_JR:   begin o = 6'h00; f = 6'h08; end
      C_JALR: begin o = 6'h00; f = 6'h09; end
      C_LD:   o = 6'h20 + 6'($urandom_range(0, 6));
      C_ST:   o = 6'h28 + 6'($urandom_range(0, 6));
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          o = 6'h00;
          while (f == 6'h08 || f == 6'h09 || f == 6'h0C) f = 6'($urandom);
        end else begin
          o = 6'($urandom);
          while (is_special(o)) o = 6'($urandom);
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input rec_t r);
    rst_n     = !r.rst;
    mem_ready = r.rdy;
    alu_zf    = r.zf;
    op        = r.io_rand ? 6'($urandom) : r.op;
    funct     = r.io_rand ? 6'($urandom) : r.funct;
    cur       = r;
    exp_valid = 1'b1;
    @(posedge clk);
    if (r.rst) begin
      m_cyc = 32'd0;
      m_ins = 32'd0;
    end else begin
      if (r.st != 3'd5) m_cyc = m_cyc + 32'd1;
      if (r.ends) m_ins = m_ins + 32'd1;
    end
    #1;
  endtask

  task automatic run_queue();
    while (q.size() > 0) applyStimulus(q.pop_front());
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      checkOutput("mem_req", mem_req, cur.req);
      checkOutput("mem_we", mem_we, cur.we);
      checkOutput("mem_iord", mem_iord, cur.iord);
      checkOutput("ir_wren", ir_wren, cur.ir);
      checkOutput("pc_wren", pc_wren, cur.pc);
      checkOutput("pc_control", pc_control, cur.ctl);
      checkOutput("reg_file_wren", reg_file_wren, cur.rf);
      checkOutput("reg_file_dmux_sel", reg_file_dmux_sel, cur.dmux);
      if (cur.chk) begin
        checkOutput("state", state, cur.st);
        checkOutput("halted", halted, cur.hlt);
`ifdef PERF_CNT_EN
        checkOutput("cycle_cnt", cycle_cnt, m_cyc);
        checkOutput("instr_cnt", instr_cnt, m_ins);
`endif
      end
    end
  end

  initial begin
    logic [5:0] o, f;
    int cls, mem_cnt;

    // Pin the model against hand-derived sequences.
    build(C_ALU, 6'h00, 6'h21, 0, 0, 1'b0);
    checkOutput("model_addu_len", q.size(), 4);
    checkOutput("model_addu_states", {q[0].st, q[1].st, q[2].st, q[3].st}, 12'o0124);
    checkOutput("model_addu_wb", {q[2].rf, q[3].rf, q[3].dmux}, 3'b011);
    q.delete();
    build(C_LD, 6'h23, 6'h00, 0, 3, 1'b0);
    mem_cnt = 0;
    foreach (q[i]) if (q[i].st == 3'd3) mem_cnt++;
    checkOutput("model_lw_len", q.size(), 8);
    checkOutput("model_lw_mem", mem_cnt, 4);
    checkOutput("model_lw_wb_dmux", {q[7].st, q[7].dmux}, 4'b1000);
    q.delete();
    build(C_JAL, 6'h03, 6'h00, 0, 0, 1'b0);
    checkOutput("model_jal", {q.size(), q[1].pc, q[1].ctl, q[1].rf}, {32'd2, 5'b10011});
    q.delete();

    @(posedge clk); #1;
    add_reset(2);
    build(C_ALU, 6'h00, 6'h21, 0, 0, 1'b0);
    build(C_LD, 6'h23, 6'h00, 0, 3, 1'b0);
    build(C_BEQ, 6'h04, 6'h00, 0, 0, 1'b1);
    build(C_BNE, 6'h05, 6'h00, 0, 0, 1'b1);
    build(C_JAL, 6'h03, 6'h00, 0, 0, 1'b0);
    run_queue();

    // Reset during a store's memory wait, held for two edges.
    build(C_ST, 6'h2B, 6'h00, 1, 4, 1'b0);
    for (int i = 0; i < 3; i++) void'(q.pop_back());
    add_reset(2);
    run_queue();

    // SYSCALL halts until a single-edge reset.
    build(C_SYS, 6'h00, 6'h0C, 0, 0, 1'b0);
    add_halt(10);
    add_reset(1);
    build(C_ALU, 6'h00, 6'h21, 0, 0, 1'b0);
    run_queue();

    for (int n = 0; n < 200; n++) begin
      cls = $urandom_range(0, 8);
      pick_op(cls, o, f);
      build(cls, o, f, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) begin
        int k = $urandom_range(1, q.size() - 1);
        for (int i = 0; i < k; i++) void'(q.pop_back());
        add_reset($urandom_range(1, 2));
      end
      run_queue();
    end

    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: all state changes on the rising edge of clk, and rst_n low at an edge resets the block.
REQ-002 SHALL have these ports (clock and reset first):
  clk  in  1  system clock
  rst_n  in  1  reset, synchronous, active-low
  op  in  6  instr[31:26] from external IR, valid DECODE onward
  funct  in  6  instr[5:0] from external IR
  alu_zf  in  1  ALU zero flag, valid in EXEC
  mem_ready  in  1  memory handshake complete this cycle
  mem_req  out  1  memory access request
  mem_we  out  1  memory write (store)
  mem_iord  out  1  0 = instruction address (PC), 1 = data address (ALU out)
  ir_wren  out  1  latch IR
  pc_wren  out  1  update PC
  pc_control  out  3  000 PC+4, 001 jump, 010 register (JR/JALR), 011 branch
  reg_file_wren  out  1  register-file write
  reg_file_dmux_sel  out  1  0 = memory data, 1 = ALU/link
  state  out  3  current FSM state
  halted  out  1  sticky halt flag
REQ-003 SHALL have no parameters; the only configurable feature is the macro in REQ-020.

Function
REQ-004 SHALL use the state encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH on the next edge.
REQ-005 FETCH: mem_req=1, mem_iord=0; hold while mem_ready=0; when mem_ready=1, assert ir_wren=1 and pc_wren=1 with pc_control=000 in that cycle, then go to DECODE.
REQ-006 DECODE handling by opcode:
  J (02): pc_wren=1, pc_control=001, then FETCH.
  JAL (03): as J, plus reg_file_wren=1 and reg_file_dmux_sel=1.
  op=00 and funct=0C (SYSCALL): go to HALT.
  All other opcodes: go to EXEC.
REQ-007 EXEC handling:
  BEQ (04): pc_wren=alu_zf, pc_control=011, then FETCH.
  BNE (05): pc_wren=!alu_zf, pc_control=011, then FETCH.
  JR (00/08): pc_wren=1, pc_control=010, then FETCH.
  JALR (00/09): as JR, plus reg_file_wren=1, then FETCH.
  Loads 20-26 and stores 28-2E: go to MEM.
  All others: go to WB.
REQ-008 MEM: mem_req=1, mem_iord=1, mem_we=1 only for stores; hold while mem_ready=0; on mem_ready=1, stores go to FETCH and loads go to WB.
REQ-009 WB: reg_file_wren=1, reg_file_dmux_sel=0 for loads and 1 otherwise; then FETCH.
REQ-010 HALT: halted=1, all enables 0, stays in HALT until reset.
REQ-011 Any output not driven in a given state SHALL be 0, except reg_file_dmux_sel, which SHALL be 1.
REQ-012 All outputs SHALL be combinational from state, op, funct, alu_zf and mem_ready; state and halted SHALL be registered.
REQ-013 mem_ready is sampled only in FETCH and MEM; in every other state it SHALL be ignored.
REQ-014 Instruction latency with zero wait states:
  J/JAL: 2 cycles.
  Branch, JR, JALR: 3 cycles.
  ALU, store: 4 cycles.
  Load: 5 cycles.
  Each memory wait cycle adds 1.
REQ-015 An opcode that matches no class SHALL be treated as an ALU instruction and SHALL NOT hang the FSM.

Reset
REQ-016 When rst_n=0 at an edge: state=FETCH, halted=0, and performance counters cleared.
REQ-017 Reset SHALL take effect in any state, including mid memory handshake; a pending mem_req SHALL drop in the cycle after the reset edge is sampled, with no IR, PC or register write in that cycle.
REQ-018 The cycle after reset release SHALL be FETCH with mem_req=1.
REQ-019 Reset SHALL be the only exit from HALT.

Configuration
REQ-020 When PERF_CNT_EN is defined, the block SHALL add these outputs:
  cycle_cnt  out  32  increments every non-HALT cycle, wraps at 2^32
  instr_cnt  out  32  increments on each transition into FETCH from a non-reset state, wraps at 2^32
REQ-021 When PERF_CNT_EN is undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-022 Reset then ADDU (op 00, funct 21), mem_ready held at 1 -> states 0,1,2,4,0; reg_file_wren=1 only in WB, with dmux_sel=1.
REQ-023 LW (op 23), mem_ready=0 for 3 cycles in MEM -> MEM held 4 cycles with mem_iord=1, mem_we=0; WB has dmux_sel=0; total 8 cycles.
REQ-024 BEQ with alu_zf=1, then BNE with alu_zf=1 -> pc_wren=1, pc_control=011 in the BEQ EXEC cycle; pc_wren=0 in the BNE EXEC cycle.
REQ-025 JAL (op 03) -> in DECODE: pc_wren=1, pc_control=001, reg_file_wren=1; next state FETCH.
REQ-026 SYSCALL (00/0C) then mem_ready toggling for 10 cycles -> halted=1 and state=5 throughout, all enables 0; rst_n=0 for one edge -> state=0, halted=0.
REQ-027 Reset asserted in MEM during an SW wait -> next cycle state=FETCH with mem_we=0; with PERF_CNT_EN defined, cycle_cnt=0 and instr_cnt=0.
